// File: rtl/mod_clk_pkg.sv
// Shared definitions for the modulation-clock generator: minimum legal
// period, reset-time configuration and the run-control state encoding.
package mod_clk_pkg;

  localparam int MIN_PERIOD = 4;
  localparam int RST_PERIOD = 8;
  localparam int RST_DEAD   = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } run_state_t;

endpackage

// File: rtl/mod_clk_chan.sv
// One channel of the modulation-clock generator. Derives the channel-local
// count from the master count and the channel phase, then decodes the
// two non-overlapping phases into registered outputs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   cnt         : master cycle counter
//   period      : active period P
//   half        : P >> 1 (end of phase A window)
//   dead        : dead time D at the start of each phase
//   phase       : this channel's phase offset (< P)
//   running     : generator is counting; outputs forced low otherwise
//   mod_clk     : phase-A clock, high for D <= lc < H
//   mod_clkn    : phase-B clock, high for H+D <= lc < P
module mod_clk_chan
  import mod_clk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] half,
  input  logic [CNT_W-1:0] dead,
  input  logic [CNT_W-1:0] phase,
  input  logic             running,
  output logic             mod_clk,
  output logic             mod_clkn
);

  // One extra bit so cnt + P - phase never wraps.
  logic [CNT_W:0] lc;
  logic [CNT_W:0] b_start;

  // NOTE: every always_comb output gets a value on every path (here via the
  // if/else pair); a missing branch would infer a latch.
  always_comb begin
    if (cnt >= phase) lc = {1'b0, cnt} - {1'b0, phase};
    else              lc = {1'b0, cnt} + {1'b0, period} - {1'b0, phase};
  end

  assign b_start = {1'b0, half} + {1'b0, dead};

  // NOTE: sequential state is assigned with <= so all registers sample the
  // pre-edge values; blocking = here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_clk  <= 1'b0;
      mod_clkn <= 1'b0;
    end else begin
      mod_clk  <= running && (lc >= {1'b0, dead}) && (lc < {1'b0, half});
      mod_clkn <= running && (lc >= b_start) && (lc < {1'b0, period});
    end
  end

endmodule

// File: rtl/mod_clk_gen.sv
// Multi-channel modulation-clock generator. A master counter runs 0..P-1 in
// the USER_CLOCK domain; each channel decodes a phase-shifted pair of
// non-overlapping clocks from it. Configuration arrives over a valid/ready
// handshake, is range-checked, held as pending and applied at a period
// boundary (or immediately while idle) so outputs never glitch.
//   USER_CLOCK, USER_RESET_N : clock, asynchronous active-low reset
//   EN                       : run request
//   CFG_VALID / CFG_READY    : config handshake
//   CFG_PERIOD/DEAD/PHASE    : offered period, dead time, per-channel phase
//   MOD_CLK / MOD_CLKN       : per-channel phase A / phase B clocks
//   MOD_CLKL                 : phase-0 reference, high for cnt < P/2
//   PERIOD_TICK              : one pulse per period, aligned with cnt = 0
//   CFG_ERR                  : one-cycle pulse after a rejected config
module mod_clk_gen
  import mod_clk_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  USER_CLOCK,
  input  logic                  USER_RESET_N,
  input  logic                  EN,
  input  logic                  CFG_VALID,
  output logic                  CFG_READY,
  input  logic [CNT_W-1:0]      CFG_PERIOD,
  input  logic [CNT_W-1:0]      CFG_DEAD,
  input  logic [N_CH*CNT_W-1:0] CFG_PHASE,
  output logic [N_CH-1:0]       MOD_CLK,
  output logic [N_CH-1:0]       MOD_CLKN,
  output logic                  MOD_CLKL,
  output logic                  PERIOD_TICK,
  output logic                  CFG_ERR
);

  run_state_t             state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       p_q;
  logic [CNT_W-1:0]       d_q;
  logic [N_CH*CNT_W-1:0]  ph_q;
  logic                   pend_valid;
  logic [CNT_W-1:0]       pend_p;
  logic [CNT_W-1:0]       pend_d;
  logic [N_CH*CNT_W-1:0]  pend_ph;

  logic [CNT_W-1:0]       half;
  logic                   running;
  logic                   wrap;
  logic                   xfer;
  logic                   apply;
  logic                   cfg_ok;

  assign half      = p_q >> 1;
  assign running   = (state != IDLE);
  assign wrap      = running && (cnt == p_q - CNT_W'(1));
  assign CFG_READY = !pend_valid;
  assign xfer      = CFG_VALID && CFG_READY;
  // Idle: take pending at once. Counting: only at the period boundary.
  assign apply     = pend_valid && ((state == IDLE) || wrap);

  // D <= H-1 is written as D < H so it cannot underflow for tiny periods.
  always_comb begin
    cfg_ok = (CFG_PERIOD >= CNT_W'(MIN_PERIOD)) && (CFG_DEAD < (CFG_PERIOD >> 1));
    for (int i = 0; i < N_CH; i++) begin
      if (CFG_PHASE[i*CNT_W +: CNT_W] >= CFG_PERIOD) cfg_ok = 1'b0;
    end
  end

  // NOTE: the config registers are reset too, not only the control state:
  // they drive the outputs directly, so they must hold known defaults.
  always_ff @(posedge USER_CLOCK or negedge USER_RESET_N) begin
    if (!USER_RESET_N) begin
      state       <= IDLE;
      cnt         <= '0;
      p_q         <= CNT_W'(RST_PERIOD);
      d_q         <= CNT_W'(RST_DEAD);
      ph_q        <= '0;
      pend_valid  <= 1'b0;
      pend_p      <= '0;
      pend_d      <= '0;
      pend_ph     <= '0;
      CFG_ERR     <= 1'b0;
      MOD_CLKL    <= 1'b0;
      PERIOD_TICK <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (EN) state <= RUN;
        RUN:      if (!EN) state <= STOPPING;
        STOPPING: begin
          if (EN)        state <= RUN;
          else if (wrap) state <= IDLE;
        end
        default:  state <= IDLE;
      endcase

      if (!running || wrap) cnt <= '0;
      else                  cnt <= cnt + CNT_W'(1);

      // apply needs pend_valid and xfer needs !pend_valid: never both.
      if (apply) begin
        p_q        <= pend_p;
        d_q        <= pend_d;
        ph_q       <= pend_ph;
        pend_valid <= 1'b0;
      end else if (xfer && cfg_ok) begin
        pend_p     <= CFG_PERIOD;
        pend_d     <= CFG_DEAD;
        pend_ph    <= CFG_PHASE;
        pend_valid <= 1'b1;
      end

      CFG_ERR     <= xfer && !cfg_ok;
      MOD_CLKL    <= running && (cnt < half);
      PERIOD_TICK <= running && (cnt == '0);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    mod_clk_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (USER_CLOCK),
      .rst_n    (USER_RESET_N),
      .cnt      (cnt),
      .period   (p_q),
      .half     (half),
      .dead     (d_q),
      .phase    (ph_q[i*CNT_W +: CNT_W]),
      .running  (running),
      .mod_clk  (MOD_CLK[i]),
      .mod_clkn (MOD_CLKN[i])
    );
  end

endmodule

// File: tb/tb_mod_clk_gen.sv
// Directed bench for mod_clk_gen. Inputs are driven and outputs sampled on
// the falling edge; each observation reflects the counter value of the
// preceding rising edge. Expected waveforms are hand-written bit tables
// indexed by that counter value.
module tb_mod_clk_gen;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [CNT_W-1:0]      cfg_period = '0;
  logic [CNT_W-1:0]      cfg_dead = '0;
  logic [N_CH*CNT_W-1:0] cfg_phase = '0;
  logic [N_CH-1:0]       mod_clk;
  logic [N_CH-1:0]       mod_clkn;
  logic                  mod_clkl;
  logic                  period_tick;
  logic                  cfg_err;

  int errors = 0;
  int checks = 0;

  // Default config (P=8, D=1, PH=0), bit c = value when cnt = c.
  logic [15:0] d_l   = 16'h000F;
  logic [15:0] d_a   = 16'h000E;
  logic [15:0] d_b   = 16'h00E0;
  logic [15:0] d_t   = 16'h0001;

  always #5 clk = ~clk;

  mod_clk_gen #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .USER_CLOCK   (clk),
    .USER_RESET_N (rst_n),
    .EN           (en),
    .CFG_VALID    (cfg_valid),
    .CFG_READY    (cfg_ready),
    .CFG_PERIOD   (cfg_period),
    .CFG_DEAD     (cfg_dead),
    .CFG_PHASE    (cfg_phase),
    .MOD_CLK      (mod_clk),
    .MOD_CLKN     (mod_clkn),
    .MOD_CLKL     (mod_clkl),
    .PERIOD_TICK  (period_tick),
    .CFG_ERR      (cfg_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Leaves the bench at the observation for cnt = 0.
  task automatic start_run();
    en = 1'b1;
    step();
    step();
  endtask

  task automatic cfg_send(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] d,
                          input logic [N_CH*CNT_W-1:0] ph);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_dead   = d;
    cfg_phase  = ph;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mod_clk, mod_clkn, mod_clkl, period_tick, cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all 0",
               {mod_clk, mod_clkn, mod_clkl, period_tick, cfg_err});
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, want 1", cfg_ready);
    end
    checks++;
    if ({mod_clk, mod_clkn, mod_clkl, period_tick} !== '0) begin
      errors++;
      $display("FAIL idle_outputs: got %b, want all 0",
               {mod_clk, mod_clkn, mod_clkl, period_tick});
    end
  endtask

  task automatic test_default_run();
    do_reset();
    en = 1'b1;
    step();
    checks++;
    if (period_tick !== 1'b0) begin
      errors++;
      $display("FAIL start_latency_early: tick got %b, want 0", period_tick);
    end
    step();
    for (int k = 0; k < 16; k++) begin
      int c;
      c = k % 8;
      checks++;
      if (mod_clkl !== d_l[c]) begin
        errors++;
        $display("FAIL default_clkl c=%0d: got %b, want %b", c, mod_clkl, d_l[c]);
      end
      checks++;
      if (mod_clk !== {N_CH{d_a[c]}}) begin
        errors++;
        $display("FAIL default_clk c=%0d: got %b, want %b", c, mod_clk, {N_CH{d_a[c]}});
      end
      checks++;
      if (mod_clkn !== {N_CH{d_b[c]}}) begin
        errors++;
        $display("FAIL default_clkn c=%0d: got %b, want %b", c, mod_clkn, {N_CH{d_b[c]}});
      end
      checks++;
      if (period_tick !== d_t[c]) begin
        errors++;
        $display("FAIL default_tick c=%0d: got %b, want %b", c, period_tick, d_t[c]);
      end
      checks++;
      if ((mod_clk & mod_clkn) !== '0) begin
        errors++;
        $display("FAIL overlap c=%0d: got %b, want 0", c, mod_clk & mod_clkn);
      end
      step();
    end
  endtask

  task automatic test_phase();
    logic [15:0] a0, b0, a1, b1;
    a0 = 16'h000F;
    b0 = 16'h00F0;
    a1 = 16'h003C;
    b1 = 16'h00C3;
    do_reset();
    cfg_send(8'd8, 8'd0, {8'd0, 8'd0, 8'd2, 8'd0});
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL phase_pending_ready: got %b, want 0", cfg_ready);
    end
    step();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL phase_idle_apply_ready: got %b, want 1", cfg_ready);
    end
    start_run();
    for (int k = 0; k < 16; k++) begin
      int c;
      c = k % 8;
      checks++;
      if (mod_clk !== {a0[c], a0[c], a1[c], a0[c]}) begin
        errors++;
        $display("FAIL phase_clk c=%0d: got %b, want %b", c, mod_clk,
                 {a0[c], a0[c], a1[c], a0[c]});
      end
      checks++;
      if (mod_clkn !== {b0[c], b0[c], b1[c], b0[c]}) begin
        errors++;
        $display("FAIL phase_clkn c=%0d: got %b, want %b", c, mod_clkn,
                 {b0[c], b0[c], b1[c], b0[c]});
      end
      step();
    end
  endtask

  task automatic test_reconfig();
    logic [15:0] l12, a12, b12;
    l12 = 16'h003F;
    a12 = 16'h003E;
    b12 = 16'h0F80;
    do_reset();
    start_run();
    step();
    step();
    cfg_send(8'd12, 8'd1, '0);
    for (int c = 3; c < 7; c++) begin
      checks++;
      if (cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL reconfig_ready_low c=%0d: got %b, want 0", c, cfg_ready);
      end
      checks++;
      if (mod_clkl !== d_l[c]) begin
        errors++;
        $display("FAIL reconfig_old_clkl c=%0d: got %b, want %b", c, mod_clkl, d_l[c]);
      end
      step();
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_ready_back: got %b, want 1", cfg_ready);
    end
    checks++;
    if (mod_clkn !== {N_CH{1'b1}}) begin
      errors++;
      $display("FAIL reconfig_last_old: clkn got %b, want 1111", mod_clkn);
    end
    for (int k = 0; k <= 12; k++) begin
      int c;
      step();
      c = k % 12;
      checks++;
      if (mod_clkl !== l12[c]) begin
        errors++;
        $display("FAIL p12_clkl c=%0d: got %b, want %b", c, mod_clkl, l12[c]);
      end
      checks++;
      if (mod_clk !== {N_CH{a12[c]}}) begin
        errors++;
        $display("FAIL p12_clk c=%0d: got %b, want %b", c, mod_clk, {N_CH{a12[c]}});
      end
      checks++;
      if (mod_clkn !== {N_CH{b12[c]}}) begin
        errors++;
        $display("FAIL p12_clkn c=%0d: got %b, want %b", c, mod_clkn, {N_CH{b12[c]}});
      end
      checks++;
      if (period_tick !== (c == 0)) begin
        errors++;
        $display("FAIL p12_tick c=%0d: got %b, want %b", c, period_tick, (c == 0));
      end
    end
  endtask

  task automatic test_invalid();
    logic [CNT_W-1:0]      bad_p  [3];
    logic [CNT_W-1:0]      bad_d  [3];
    logic [N_CH*CNT_W-1:0] bad_ph [3];
    bad_p[0] = 8'd3; bad_d[0] = 8'd0; bad_ph[0] = '0;
    bad_p[1] = 8'd8; bad_d[1] = 8'd4; bad_ph[1] = '0;
    bad_p[2] = 8'd8; bad_d[2] = 8'd1; bad_ph[2] = {8'd0, 8'd8, 8'd0, 8'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cfg_send(bad_p[i], bad_d[i], bad_ph[i]);
      checks++;
      if (cfg_err !== 1'b1) begin
        errors++;
        $display("FAIL invalid%0d_err: got %b, want 1", i, cfg_err);
      end
      checks++;
      if (cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL invalid%0d_ready: got %b, want 1", i, cfg_ready);
      end
      step();
      checks++;
      if (cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL invalid%0d_pulse: got %b, want 0", i, cfg_err);
      end
    end
    start_run();
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({mod_clkl, mod_clk[2], mod_clkn[2], period_tick} !==
          {d_l[c], d_a[c], d_b[c], d_t[c]}) begin
        errors++;
        $display("FAIL invalid_keeps_cfg c=%0d: got %b, want %b", c,
                 {mod_clkl, mod_clk[2], mod_clkn[2], period_tick},
                 {d_l[c], d_a[c], d_b[c], d_t[c]});
      end
      step();
    end
  endtask

  task automatic test_stop();
    do_reset();
    start_run();
    step();
    en = 1'b0;
    for (int c = 2; c < 8; c++) begin
      step();
      checks++;
      if ({mod_clkl, mod_clk, mod_clkn, period_tick} !==
          {d_l[c], {N_CH{d_a[c]}}, {N_CH{d_b[c]}}, d_t[c]}) begin
        errors++;
        $display("FAIL stop_complete c=%0d: got %b, want %b", c,
                 {mod_clkl, mod_clk, mod_clkn, period_tick},
                 {d_l[c], {N_CH{d_a[c]}}, {N_CH{d_b[c]}}, d_t[c]});
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({mod_clkl, mod_clk, mod_clkn, period_tick} !== '0) begin
        errors++;
        $display("FAIL stop_idle k=%0d: got %b, want all 0", k,
                 {mod_clkl, mod_clk, mod_clkn, period_tick});
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (period_tick !== 1'b0) begin
      errors++;
      $display("FAIL restart_early: tick got %b, want 0", period_tick);
    end
    step();
    checks++;
    if ({period_tick, mod_clkl} !== 2'b11) begin
      errors++;
      $display("FAIL restart_tick: got %b, want 11", {period_tick, mod_clkl});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_run();
    step();
    step();
    cfg_send(8'd12, 8'd1, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mod_clk, mod_clkn, mod_clkl, period_tick, cfg_err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b, want all 0",
               {mod_clk, mod_clkn, mod_clkl, period_tick, cfg_err});
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pending: ready got %b, want 1", cfg_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    for (int k = 0; k < 9; k++) begin
      int c;
      c = k % 8;
      checks++;
      if ({mod_clkl, mod_clk[0], mod_clkn[0], period_tick} !==
          {d_l[c], d_a[c], d_b[c], d_t[c]}) begin
        errors++;
        $display("FAIL midreset_defaults c=%0d: got %b, want %b", c,
                 {mod_clkl, mod_clk[0], mod_clkn[0], period_tick},
                 {d_l[c], d_a[c], d_b[c], d_t[c]});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_phase();
    test_reconfig();
    test_invalid();
    test_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
